board_level_data_receiver: RTL and testbench

Receive-side counterpart of the board-level stream transmitter. Consumes the 6-bit symbol stream delivered by the receive physical layer and reassembles it into 8-bit bytes, undoing the transmitter's 3-byte-to-4-symbol packing. It withholds the trailing CRC byte, checks it against a running CRC-8/MAXIM, and reports frame boundaries and a per-frame error flag to the user side.

---
 rtl/board_level_data_receiver_pkg.sv | 17 +
 rtl/board_level_data_receiver_crc8.sv | 18 +
 rtl/board_level_data_receiver.sv | 167 ++++++++++++++++
 tb/tb_board_level_data_receiver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/board_level_data_receiver_pkg.sv
// Shared encodings for the board-level stream link (receiver and transmitter).
package board_level_data_receiver_pkg;

  localparam int SYM_WIDTH  = 6;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_DATA = 1'b1
  } rx_state_e;

  localparam logic [1:0] PHASE_0 = 2'd0;
  localparam logic [1:0] PHASE_1 = 2'd1;
  localparam logic [1:0] PHASE_2 = 2'd2;
  localparam logic [1:0] PHASE_3 = 2'd3;

endpackage

// File: rtl/board_level_data_receiver_crc8.sv
// Combinational single-byte step of CRC-8/MAXIM (reflected poly 0x31, LSB first).
module crc8_maxim (
  input  logic [7:0] last_crc,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] w_c;

  always_comb begin
    w_c = last_crc ^ data;
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ 8'h8C) : (w_c >> 1);
    end
    crc = w_c;
  end

endmodule

// File: rtl/board_level_data_receiver.sv
// Reassembles 6-bit symbols into bytes, withholds the trailing CRC byte and
// reports a per-frame CRC-8/MAXIM verdict on frame_end.
module board_level_data_receiver
  import board_level_data_receiver_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sym_frame_start,
  input  logic                  sym_frame_end,
  input  logic                  sym_valid,
  input  logic [SYM_WIDTH-1:0]  sym_data,
  output logic                  frame_start,
  output logic [BYTE_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  frame_end,
  output logic                  crc_error,
  output logic                  busy
);

  rx_state_e             r_state, w_state_nxt;
  logic [1:0]            r_phase, w_phase_nxt;
  logic [SYM_WIDTH-1:0]  r_resid, w_resid_nxt;
  logic [BYTE_WIDTH-1:0] r_held_byte, w_held_byte_nxt;
  logic                  r_held_valid, w_held_valid_nxt;
  logic [BYTE_WIDTH-1:0] r_crc, w_crc_nxt;

  logic                  r_frame_start, w_frame_start;
  logic [BYTE_WIDTH-1:0] r_data, w_data;
  logic                  r_data_valid, w_data_valid;
  logic                  r_frame_end, w_frame_end;
  logic                  r_crc_error, w_crc_error;

  logic [BYTE_WIDTH-1:0] w_crc_upd;
  logic [BYTE_WIDTH-1:0] w_asm_byte;
  logic [SYM_WIDTH-1:0]  w_asm_resid;
  logic                  w_asm_done;
  logic                  w_close_err;

  crc8_maxim u_crc (
    .last_crc (r_crc),
    .data     (r_held_byte),
    .crc      (w_crc_upd)
  );

  // Candidate assembler step for the current symbol; only committed when accepted.
  always_comb begin
    w_asm_byte  = '0;
    w_asm_resid = '0;
    w_asm_done  = 1'b0;
    case (r_phase)
      PHASE_0: w_asm_resid = sym_data;
      PHASE_1: begin
        w_asm_byte  = {r_resid[5:0], sym_data[5:4]};
        w_asm_resid = {2'b00, sym_data[3:0]};
        w_asm_done  = 1'b1;
      end
      PHASE_2: begin
        w_asm_byte  = {r_resid[3:0], sym_data[5:2]};
        w_asm_resid = {4'b0000, sym_data[1:0]};
        w_asm_done  = 1'b1;
      end
      default: begin
        w_asm_byte  = {r_resid[1:0], sym_data[5:0]};
        w_asm_resid = '0;
        w_asm_done  = 1'b1;
      end
    endcase
  end

  // Close verdict: CRC byte present and matching, legal phase, zero padding.
  always_comb begin
    w_close_err = !r_held_valid || (r_held_byte != r_crc) || (r_phase == PHASE_1);
    if (r_phase == PHASE_2 && r_resid[3:0] != 4'd0) w_close_err = 1'b1;
    if (r_phase == PHASE_3 && r_resid[1:0] != 2'd0) w_close_err = 1'b1;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_resid_nxt      = r_resid;
    w_held_byte_nxt  = r_held_byte;
    w_held_valid_nxt = r_held_valid;
    w_crc_nxt        = r_crc;
    w_frame_start    = 1'b0;
    w_frame_end      = 1'b0;
    w_crc_error      = 1'b0;
    w_data_valid     = 1'b0;
    w_data           = '0;

    case (r_state)
      RX_IDLE: begin
        if (sym_frame_start) begin
          w_state_nxt      = RX_DATA;
          w_frame_start    = 1'b1;
          w_phase_nxt      = PHASE_0;
          w_resid_nxt      = '0;
          w_held_valid_nxt = 1'b0;
          w_crc_nxt        = '0;
        end
      end
      RX_DATA: begin
        if (sym_frame_start) begin
          // Abort: close the current frame as bad and open a fresh one.
          w_frame_end      = 1'b1;
          w_crc_error      = 1'b1;
          w_frame_start    = 1'b1;
          w_phase_nxt      = PHASE_0;
          w_resid_nxt      = '0;
          w_held_valid_nxt = 1'b0;
          w_crc_nxt        = '0;
        end else if (sym_frame_end) begin
          w_frame_end = 1'b1;
          w_crc_error = w_close_err;
          w_state_nxt = RX_IDLE;
        end else if (sym_valid) begin
          w_phase_nxt = r_phase + 2'd1;
          w_resid_nxt = w_asm_resid;
          if (w_asm_done) begin
            if (r_held_valid) begin
              w_data_valid = 1'b1;
              w_data       = r_held_byte;
              w_crc_nxt    = w_crc_upd;
            end
            w_held_byte_nxt  = w_asm_byte;
            w_held_valid_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RX_IDLE;
      r_phase       <= PHASE_0;
      r_resid       <= '0;
      r_held_byte   <= '0;
      r_held_valid  <= 1'b0;
      r_crc         <= '0;
      r_frame_start <= 1'b0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_frame_end   <= 1'b0;
      r_crc_error   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_resid       <= w_resid_nxt;
      r_held_byte   <= w_held_byte_nxt;
      r_held_valid  <= w_held_valid_nxt;
      r_crc         <= w_crc_nxt;
      r_frame_start <= w_frame_start;
      r_data        <= w_data;
      r_data_valid  <= w_data_valid;
      r_frame_end   <= w_frame_end;
      r_crc_error   <= w_crc_error;
    end
  end

  assign frame_start = r_frame_start;
  assign data        = r_data;
  assign data_valid  = r_data_valid;
  assign frame_end   = r_frame_end;
  assign crc_error   = r_crc_error;
  assign busy        = (r_state == RX_DATA);

endmodule

// File: tb/tb_board_level_data_receiver.sv
// Directed bench: table of frames with hand-computed bytes/verdicts plus
// hand-written abort, back-to-back, idle-garbage and reset sequences.
module tb_board_level_data_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       sym_frame_start, sym_frame_end, sym_valid;
  logic [5:0] sym_data;
  logic       frame_start, data_valid, frame_end, crc_error, busy;
  logic [7:0] data;

  board_level_data_receiver dut (
    .clk(clk), .rst(rst),
    .sym_frame_start(sym_frame_start), .sym_frame_end(sym_frame_end),
    .sym_valid(sym_valid), .sym_data(sym_data),
    .frame_start(frame_start), .data(data), .data_valid(data_valid),
    .frame_end(frame_end), .crc_error(crc_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge.
  logic [7:0] q[$];
  bit         errq[$];
  int         fs_cnt = 0, fe_cnt = 0, stray = 0;

  always @(negedge clk) begin
    if (data_valid) q.push_back(data);
    if (frame_start) fs_cnt++;
    if (frame_end) begin fe_cnt++; errq.push_back(crc_error); end
    if (!frame_end && crc_error) stray++;
  end

  int pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    sym_frame_start = 0; sym_frame_end = 0; sym_valid = 0; sym_data = '0;
  endtask

  task automatic pulse_start; sym_frame_start = 1; tick; sym_frame_start = 0; endtask
  task automatic pulse_end;   sym_frame_end = 1;   tick; sym_frame_end = 0;   endtask

  task automatic send(input int n, input logic [15:0][5:0] s, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick;
      sym_valid = 1; sym_data = s[k]; tick;
      sym_valid = 0; sym_data = '0;
    end
  endtask

  // MSB-first packing of bytes into 6-bit symbols, zero padded.
  function automatic logic [15:0][5:0] pack(input logic [11:0][7:0] by, input int nb);
    logic [95:0] bs;
    logic [15:0][5:0] s;
    bs = '0; s = '0;
    for (int i = 0; i < nb; i++) bs[95-8*i -: 8] = by[i];
    for (int k = 0; k < 16; k++) s[k] = bs[95-6*k -: 6];
    return s;
  endfunction

  typedef struct {
    string            name;
    int               nsym;
    logic [15:0][5:0] syms;
    bit               gaps;
    int               nexp;
    logic [11:0][7:0] exp;
    bit               exp_err;
  } vec_t;

  vec_t vt[10];
  logic [11:0][7:0] nom_b, zero_b, bad_b, nom_exp, cor_exp;
  logic [15:0][5:0] nom_s;

  initial begin
    int qb, fb, eb;
    idle_in();
    rst = 1;

    for (int i = 0; i < 12; i++) begin
      nom_b[i] = (i < 9) ? 8'h31 + 8'(i) : 8'h00;
      zero_b[i] = 8'h00;
    end
    nom_b[9] = 8'hA1;
    bad_b = nom_b; bad_b[9] = 8'hA2;
    nom_exp = nom_b; nom_exp[9] = 8'h00;
    cor_exp = nom_exp; cor_exp[3] = 8'h30;
    nom_s = pack(nom_b, 10);

    vt[0] = '{"nominal",    14, nom_s,                      1'b0, 9, nom_exp, 1'b0};
    vt[1] = '{"crc_only",    2, pack(zero_b, 1),            1'b0, 0, zero_b,  1'b0};
    vt[2] = '{"close_ph3",   3, pack(zero_b, 2),            1'b0, 1, zero_b,  1'b0};
    vt[3] = '{"close_ph0",   4, pack(zero_b, 3),            1'b0, 2, zero_b,  1'b0};
    vt[4] = '{"corrupt",    14, nom_s,                      1'b0, 9, cor_exp, 1'b1};
    vt[4].syms[4] = nom_s[4] ^ 6'h01;
    vt[5] = '{"close_ph1",   5, nom_s,                      1'b0, 2, nom_exp, 1'b1};
    vt[6] = '{"bad_crc",    14, pack(bad_b, 10),            1'b0, 9, nom_exp, 1'b1};
    vt[7] = '{"pad_nonzero",14, nom_s,                      1'b0, 9, nom_exp, 1'b1};
    vt[7].syms[13] = nom_s[13] | 6'h01;
    vt[8] = '{"gapped",     14, nom_s,                      1'b1, 9, nom_exp, 1'b0};
    vt[9] = '{"empty",       0, nom_s,                      1'b0, 0, nom_exp, 1'b1};

    // Reset state
    tick; tick;
    chk("reset_outputs", {26'd0, frame_start, data_valid, frame_end, crc_error, busy, |data}, 32'd0);
    rst = 0; tick;

    // Garbage in IDLE must be ignored
    qb = q.size(); fb = fs_cnt; eb = fe_cnt;
    sym_valid = 1; sym_data = 6'h3F; sym_frame_end = 1;
    repeat (3) tick;
    idle_in(); tick; tick;
    chk("idle_no_bytes", q.size() - qb, 0);
    chk("idle_no_fe", fe_cnt - eb, 0);
    chk("idle_no_fs", fs_cnt - fb, 0);
    chk("idle_busy", busy, 0);

    foreach (vt[v]) begin
      qb = q.size(); fb = fs_cnt; eb = fe_cnt;
      pulse_start();
      chk({vt[v].name, "_busy"}, busy, 1);
      send(vt[v].nsym, vt[v].syms, vt[v].gaps);
      pulse_end();
      repeat (3) tick;
      chk({vt[v].name, "_fs"}, fs_cnt - fb, 1);
      chk({vt[v].name, "_fe"}, fe_cnt - eb, 1);
      chk({vt[v].name, "_nbytes"}, q.size() - qb, vt[v].nexp);
      for (int i = 0; i < vt[v].nexp && qb + i < q.size(); i++)
        chk($sformatf("%s_byte%0d", vt[v].name, i), q[qb+i], vt[v].exp[i]);
      if (fe_cnt > eb) chk({vt[v].name, "_err"}, errq[eb], vt[v].exp_err);
    end

    // Abort after 4 symbols; start wins over coincident end and valid
    qb = q.size(); fb = fs_cnt; eb = fe_cnt;
    pulse_start();
    send(4, nom_s, 1'b0);
    sym_frame_start = 1; sym_frame_end = 1; sym_valid = 1; sym_data = 6'h3F;
    tick; idle_in();
    send(14, nom_s, 1'b0);
    pulse_end();
    repeat (3) tick;
    chk("abort_fs", fs_cnt - fb, 2);
    chk("abort_fe", fe_cnt - eb, 2);
    chk("abort_nbytes", q.size() - qb, 11);
    if (fe_cnt - eb >= 2) begin
      chk("abort_err1", errq[eb], 1);
      chk("abort_err2", errq[eb+1], 0);
    end
    if (q.size() - qb >= 11) begin
      chk("abort_b0", q[qb], 8'h31);
      chk("abort_b1", q[qb+1], 8'h32);
      for (int i = 0; i < 9; i++) chk($sformatf("abort_f2_b%0d", i), q[qb+2+i], nom_exp[i]);
    end

    // Back-to-back frames with no dead cycle
    qb = q.size(); fb = fs_cnt; eb = fe_cnt;
    pulse_start();
    send(2, pack(zero_b, 1), 1'b0);
    pulse_end();
    pulse_start();
    send(14, nom_s, 1'b0);
    pulse_end();
    repeat (3) tick;
    chk("b2b_fs", fs_cnt - fb, 2);
    chk("b2b_fe", fe_cnt - eb, 2);
    chk("b2b_nbytes", q.size() - qb, 9);
    if (fe_cnt - eb >= 2) chk("b2b_errs", {errq[eb], errq[eb+1]}, 0);

    // Reset mid-frame drops the frame silently
    eb = fe_cnt;
    pulse_start();
    send(6, nom_s, 1'b0);
    rst = 1; tick;
    chk("rst_mid_outputs", {26'd0, frame_start, data_valid, frame_end, crc_error, busy, |data}, 32'd0);
    tick; rst = 0; tick;
    chk("rst_no_fe", fe_cnt - eb, 0);
    qb = q.size(); eb = fe_cnt;
    pulse_start();
    send(14, nom_s, 1'b0);
    pulse_end();
    repeat (3) tick;
    chk("rst_f2_fe", fe_cnt - eb, 1);
    chk("rst_f2_nbytes", q.size() - qb, 9);
    if (q.size() - qb >= 9) chk("rst_f2_last", q[qb+8], 8'h39);
    if (fe_cnt > eb) chk("rst_f2_err", errq[eb], 0);

    chk("stray_crc_error", stray, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
